// File: rtl/ada_pulse_frontend.sv
// Per-channel ADC front-end: offset-binary to signed conversion, boxcar smoothing,
// threshold/hysteresis/hold-off pulse detection with stats, and a selectable DAC monitor source.
module ada_pulse_frontend #(
    parameter int DATA_W    = 14,
    parameter int NUM_CH    = 2,
    parameter int AVG_LOG2  = 2,
    parameter int HOLDOFF_W = 16
) (
    input  logic                       CLOCK_65,
    input  logic                       RESET,
    input  logic [NUM_CH*DATA_W-1:0]   ADC_DATA,
    input  logic [NUM_CH-1:0]          ADC_OTR,
    input  logic [1:0]                 MODE,
    input  logic [DATA_W-1:0]          THRESH_HI,
    input  logic [DATA_W-1:0]          THRESH_LO,
    input  logic [HOLDOFF_W-1:0]       HOLDOFF,
    input  logic                       CLR_STATS,
    output logic [NUM_CH*DATA_W-1:0]   DAC_DATA,
    output logic [NUM_CH-1:0]          PULSE_VALID,
    output logic [NUM_CH*DATA_W-1:0]   PULSE_PEAK,
    output logic [NUM_CH*16-1:0]       PULSE_WIDTH,
    output logic [NUM_CH*32-1:0]       PULSE_COUNT,
    output logic [NUM_CH-1:0]          OTR_STICKY
);

    localparam int AVG_N = 1 << AVG_LOG2;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0]    adc_ch;
            logic [DATA_W-1:0]    raw_reg;
            logic [DATA_W-1:0]    s1_reg;
            logic                 otr_reg;
            logic [ACC_W-1:0]     sum;
            logic [DATA_W-1:0]    filt_reg;
            logic [DATA_W-1:0]    ramp_reg;
            logic [DATA_W-1:0]    dac_reg;

            state_t               state_reg, state_next;
            logic [DATA_W-1:0]    peak_reg, peak_next;
            logic [15:0]          width_reg, width_next;
            logic [HOLDOFF_W-1:0] cnt_reg, cnt_next;
            logic                 end_pulse;

            logic                 valid_reg;
            logic [DATA_W-1:0]    peak_out_reg;
            logic [15:0]          width_out_reg;
            logic [31:0]          count_reg;
            logic                 sticky_reg;

            assign adc_ch = ADC_DATA[gi*DATA_W +: DATA_W];

            // Window holds the previous AVG_N-1 converted samples; the current one is s1_reg.
            if (AVG_LOG2 > 0) begin : g_box
                logic [DATA_W-1:0] win_reg [AVG_N-1];

                always_ff @(posedge CLOCK_65) begin
                    if (RESET) begin
                        for (int i = 0; i < AVG_N-1; i++) win_reg[i] <= '0;
                    end else begin
                        win_reg[0] <= s1_reg;
                        for (int i = 1; i < AVG_N-1; i++) win_reg[i] <= win_reg[i-1];
                    end
                end

                always_comb begin
                    sum = {{AVG_LOG2{s1_reg[DATA_W-1]}}, s1_reg};
                    for (int i = 0; i < AVG_N-1; i++)
                        sum = sum + {{AVG_LOG2{win_reg[i][DATA_W-1]}}, win_reg[i]};
                end
            end else begin : g_nobox
                assign sum = s1_reg;
            end

            always_ff @(posedge CLOCK_65) begin
                if (RESET) begin
                    raw_reg  <= '0;
                    s1_reg   <= '0;
                    otr_reg  <= 1'b0;
                    filt_reg <= '0;
                    ramp_reg <= '0;
                    dac_reg  <= MIDSCALE;
                end else begin
                    raw_reg  <= adc_ch;
                    s1_reg   <= {~adc_ch[DATA_W-1], adc_ch[DATA_W-2:0]};
                    otr_reg  <= ADC_OTR[gi];
                    filt_reg <= sum[ACC_W-1 -: DATA_W];
                    ramp_reg <= ramp_reg + DATA_W'(1);
                    case (MODE)
                        2'd0:    dac_reg <= MIDSCALE;
                        2'd1:    dac_reg <= raw_reg;
                        2'd2:    dac_reg <= ramp_reg;
                        default: dac_reg <= {~filt_reg[DATA_W-1], filt_reg[DATA_W-2:0]};
                    endcase
                end
            end

            always_ff @(posedge CLOCK_65) begin
                if (RESET) begin
                    state_reg <= ST_IDLE;
                    peak_reg  <= '0;
                    width_reg <= '0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    peak_reg  <= peak_next;
                    width_reg <= width_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // The sample that ends a pulse contributes to neither peak nor width.
            always_comb begin
                state_next = state_reg;
                peak_next  = peak_reg;
                width_next = width_reg;
                cnt_next   = cnt_reg;
                end_pulse  = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if ($signed(filt_reg) > $signed(THRESH_HI)) begin
                            state_next = ST_PULSE;
                            peak_next  = filt_reg;
                            width_next = 16'd1;
                        end
                    end
                    ST_PULSE: begin
                        if ($signed(filt_reg) < $signed(THRESH_LO)) begin
                            end_pulse = 1'b1;
                            if (HOLDOFF == '0) begin
                                state_next = ST_IDLE;
                            end else begin
                                state_next = ST_HOLD;
                                cnt_next   = HOLDOFF;
                            end
                        end else begin
                            if ($signed(filt_reg) > $signed(peak_reg)) peak_next = filt_reg;
                            if (width_reg != 16'hFFFF) width_next = width_reg + 16'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_reg <= HOLDOFF_W'(1)) state_next = ST_IDLE;
                        else cnt_next = cnt_reg - HOLDOFF_W'(1);
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge CLOCK_65) begin
                if (RESET) begin
                    valid_reg     <= 1'b0;
                    peak_out_reg  <= '0;
                    width_out_reg <= '0;
                    count_reg     <= '0;
                    sticky_reg    <= 1'b0;
                end else begin
                    valid_reg <= end_pulse;
                    if (end_pulse) begin
                        peak_out_reg  <= peak_reg;
                        width_out_reg <= width_reg;
                    end
                    if (CLR_STATS) count_reg <= '0;
                    else if (end_pulse && count_reg != 32'hFFFF_FFFF) count_reg <= count_reg + 32'd1;
                    if (CLR_STATS) sticky_reg <= 1'b0;
                    else if (otr_reg) sticky_reg <= 1'b1;
                end
            end

            assign DAC_DATA[gi*DATA_W +: DATA_W]   = dac_reg;
            assign PULSE_VALID[gi]                 = valid_reg;
            assign PULSE_PEAK[gi*DATA_W +: DATA_W] = peak_out_reg;
            assign PULSE_WIDTH[gi*16 +: 16]        = width_out_reg;
            assign PULSE_COUNT[gi*32 +: 32]        = count_reg;
            assign OTR_STICKY[gi]                  = sticky_reg;
        end
    endgenerate

endmodule
